// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8-requester round-robin arbiter.
//   W      : data word width
//   N      : requester count (fixed by the 8:1 datapath mux)
//   SEL_W  : mux select width, log2(N)
//   state_t: arbiter FSM encoding
package mux8_arb_pkg;

  localparam int W     = 32;
  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/MUX8T1_32.sv
// 8:1 word multiplexer datapath shared by the arbiter.
// Ports:
//   s  [SEL_W-1:0] in   select
//   I0..I7 [W-1:0] in   candidate words
//   o  [W-1:0]     out  selected word
module MUX8T1_32
  import mux8_arb_pkg::*;
(
  input  logic [SEL_W-1:0] s,
  input  logic [W-1:0]     I0,
  input  logic [W-1:0]     I1,
  input  logic [W-1:0]     I2,
  input  logic [W-1:0]     I3,
  input  logic [W-1:0]     I4,
  input  logic [W-1:0]     I5,
  input  logic [W-1:0]     I6,
  input  logic [W-1:0]     I7,
  output logic [W-1:0]     o
);

  always_comb begin
    case (s)
      3'd0:    o = I0;
      3'd1:    o = I1;
      3'd2:    o = I2;
      3'd3:    o = I3;
      3'd4:    o = I4;
      3'd5:    o = I5;
      3'd6:    o = I6;
      default: o = I7;
    endcase
  end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker.
// Searches req starting at ptr+1 and wrapping 7->0; the first set bit wins.
// Ports:
//   req [N-1:0]     in   pending requests
//   ptr [SEL_W-1:0] in   index of the last grant
//   any             out  at least one request pending
//   idx [SEL_W-1:0] out  winning index (meaningful only when any=1)
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] start;
  logic [2*N-1:0]   dbl;
  logic [2*N-1:0]   dbl_sh;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit 0 of rot is requester ptr+1, then plain priority,
  // then add the rotation back to recover the absolute index.
  assign start  = ptr + SEL_W'(1);
  assign dbl    = {req, req};
  assign dbl_sh = dbl >> start;
  assign rot    = dbl_sh[N-1:0];

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = SEL_W'(j);
    end
  end

  assign idx = start + off;
  assign any = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing the 8:1 x 32-bit mux among 8 requesters.
// The winning word is registered and offered downstream on valid/ready,
// with a one-hot grant returned to the requesters while the word is pending.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no word pending downstream
// XFER  | o holds an unconsumed word, waiting for o_ready
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   per-requester pending flags
//   I0..I7   in   requester data words
//   o_ready  in   consumer accepts o this cycle
//   o        out  registered selected word
//   o_valid  out  o holds an unconsumed word
//   s        out  select of the current/last grant
//   gnt      out  one-hot grant while the granted word is pending
//   busy     out  same as o_valid
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [W-1:0]     I0,
  input  logic [W-1:0]     I1,
  input  logic [W-1:0]     I2,
  input  logic [W-1:0]     I3,
  input  logic [W-1:0]     I4,
  input  logic [W-1:0]     I5,
  input  logic [W-1:0]     I6,
  input  logic [W-1:0]     I7,
  input  logic             o_ready,
  output logic [W-1:0]     o,
  output logic             o_valid,
  output logic [SEL_W-1:0] s,
  output logic [N-1:0]     gnt,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [W-1:0]     o_q, o_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [W-1:0]     mux_word;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  MUX8T1_32 u_mux (
    .s  (pick_idx),
    .I0 (I0),
    .I1 (I1),
    .I2 (I2),
    .I3 (I3),
    .I4 (I4),
    .I5 (I5),
    .I6 (I6),
    .I7 (I7),
    .o  (mux_word)
  );

  // While a transfer completes, ptr still holds the current grant, so the
  // picker naturally prefers every other requester and only falls back to
  // the current one when it is the sole contender.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;

    if (state_q == IDLE || o_ready) begin
      if (pick_any) begin
        state_d = XFER;
        o_d     = mux_word;
        s_d     = pick_idx;
        gnt_d   = onehot(pick_idx);
        ptr_d   = pick_idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      ptr_q   <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o       = o_q;
  assign s       = s_q;
  assign gnt     = gnt_q;
  assign o_valid = (state_q == XFER);
  assign busy    = o_valid;

endmodule
